// File: rtl/i2c_pkg.sv
// Shared types for the I2C register master.
//   status_t : response status code returned with every request
//   state_t  : sequencer state encoding
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_NACK_ADDR = 3'd1,
    ST_NACK_DATA = 3'd2,
    ST_ARB_LOST  = 3'd3,
    ST_START_ERR = 3'd4,
    ST_TIMEOUT   = 3'd5,
    ST_BAD_REQ   = 3'd6
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR_W    = 4'd1,
    S_REG       = 4'd2,
    S_WDATA     = 4'd3,
    S_RADDR     = 4'd4,
    S_RDATA     = 4'd5,
    S_DRAIN     = 4'd6,
    S_WAIT_FREE = 4'd7,
    S_RESP      = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_register_master.sv
// Register-access sequencer in front of i2c_core. Turns one request
// (device, register, up to MAX_LEN bytes, read or write) into the byte-level
// handshake of the core and returns one response per request.
//
// Ports
//   clk_in, reset                 clock, synchronous active-high reset
//   req_*                         request handshake and fields
//   rsp_*                         one-cycle response pulse, held fields
//   transfer_start/continues,
//   mode, data_tx                 byte descriptor to i2c_core
//   transfer_ready, transaction_complete, nack, start_err,
//   arbitration_err, data_rx      status and read data from i2c_core
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a request
// ADDR_W    | device address with write bit in flight
// REG       | register address in flight
// WDATA     | write data byte in flight
// RADDR     | device address with read bit in flight (after repeated START)
// RDATA     | read data byte in flight
// DRAIN     | 0xFF terminator for a byte the core already committed to
// WAIT_FREE | waiting for the bus to become free
// RESP      | response pulse
module i2c_register_master
  import i2c_pkg::*;
#(
  parameter int  MAX_LEN        = 4,
  parameter int  TIMEOUT_CYCLES = 2**20,
  localparam int LEN_WIDTH      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_read,
  input  logic [6:0]           req_dev_addr,
  input  logic [7:0]           req_reg_addr,
  input  logic [LEN_WIDTH-1:0] req_len,
  input  logic [8*MAX_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_status,
  output logic [LEN_WIDTH-1:0] rsp_count,
  output logic [8*MAX_LEN-1:0] rsp_rdata,
  output logic                 transfer_start,
  output logic                 transfer_continues,
  output logic                 mode,
  output logic [7:0]           data_tx,
  input  logic                 transfer_ready,
  input  logic                 transaction_complete,
  input  logic                 nack,
  input  logic                 start_err,
  input  logic                 arbitration_err,
  input  logic [7:0]           data_rx
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  state_t               state_q, state_d;
  status_t              status_q, status_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [8*MAX_LEN-1:0] rdata_q, rdata_d;
  logic                 ts_q, ts_d;
  logic                 tc_q, tc_d;
  logic                 mode_q, mode_d;
  logic [7:0]           data_tx_q, data_tx_d;
  logic                 rd_q, rd_d;
  logic [6:0]           dev_q, dev_d;
  logic [7:0]           reg_q, reg_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [8*MAX_LEN-1:0] wdata_q, wdata_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;

  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 cur_last;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= S_IDLE;
      status_q    <= ST_OK;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      count_q     <= '0;
      rdata_q     <= '0;
      ts_q        <= 1'b0;
      tc_q        <= 1'b0;
      mode_q      <= 1'b0;
      data_tx_q   <= '0;
      rd_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      ts_q        <= ts_d;
      tc_q        <= tc_d;
      mode_q      <= mode_d;
      data_tx_q   <= data_tx_d;
      rd_q        <= rd_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      tmr_q       <= tmr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    ts_d      = ts_q;
    tc_d      = tc_q;
    mode_d    = mode_q;
    data_tx_d = data_tx_q;
    rd_d      = rd_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    tmr_d     = tmr_q;
    cnt_inc   = count_q + LEN_WIDTH'(1);

    // Is the byte currently in flight the final one of the request?
    case (state_q)
      S_REG:   cur_last = !rd_q && (len_q == '0);
      S_WDATA: cur_last = (cnt_inc == len_q);
      default: cur_last = 1'b0;
    endcase

    if (state_q == S_IDLE) begin
      if (req_valid) begin
        count_d = '0;
        rdata_d = '0;
        tmr_d   = TMR_LOAD;
        rd_d    = req_read;
        dev_d   = req_dev_addr;
        reg_d   = req_reg_addr;
        len_d   = req_len;
        wdata_d = req_wdata;
        if ((req_len > LEN_WIDTH'(MAX_LEN)) || (req_read && (req_len == '0))) begin
          status_d = ST_BAD_REQ;
          state_d  = S_RESP;
        end else begin
          status_d  = ST_OK;
          state_d   = S_ADDR_W;
          data_tx_d = {req_dev_addr, 1'b0};
          ts_d      = 1'b1;
          tc_d      = 1'b1;
          mode_d    = 1'b0;
        end
      end
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end else if (arbitration_err || start_err) begin
      ts_d     = 1'b0;
      tc_d     = 1'b0;
      status_d = arbitration_err ? ST_ARB_LOST : ST_START_ERR;
      state_d  = S_RESP;
    end else if ((state_q == S_WAIT_FREE) && transfer_ready) begin
      state_d = S_RESP;
    end else if (transaction_complete) begin
      tmr_d = TMR_LOAD;
      if (nack && (state_q inside {S_ADDR_W, S_REG, S_RADDR, S_WDATA})) begin
        status_d = ((state_q == S_ADDR_W) || (state_q == S_RADDR)) ? ST_NACK_ADDR
                                                                     : ST_NACK_DATA;
        if (cur_last) begin
          state_d = S_WAIT_FREE;
        end else begin
          // The core already latched "one more byte"; feed it a harmless
          // terminator that ends with STOP.
          data_tx_d = 8'hFF;
          mode_d    = 1'b0;
          tc_d      = 1'b0;
          ts_d      = 1'b0;
          state_d   = S_DRAIN;
        end
      end else begin
        case (state_q)
          S_ADDR_W: begin
            state_d   = S_REG;
            data_tx_d = reg_q;
            if (rd_q) begin
              // continues=0 with start=1 asks for a repeated START
              ts_d = 1'b1;
              tc_d = 1'b0;
            end else begin
              ts_d = (len_q != '0);
              tc_d = (len_q != '0);
            end
          end
          S_REG: begin
            if (rd_q) begin
              state_d   = S_RADDR;
              data_tx_d = {dev_q, 1'b1};
              ts_d      = 1'b1;
              tc_d      = 1'b1;
              mode_d    = 1'b0;
            end else if (len_q == '0) begin
              state_d = S_WAIT_FREE;
            end else begin
              state_d   = S_WDATA;
              data_tx_d = wdata_q[7:0];
              wdata_d   = wdata_q >> 8;
              ts_d      = (len_q != LEN_WIDTH'(1));
              tc_d      = (len_q != LEN_WIDTH'(1));
            end
          end
          S_WDATA: begin
            count_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = S_WAIT_FREE;
            end else begin
              data_tx_d = wdata_q[7:0];
              wdata_d   = wdata_q >> 8;
              ts_d      = ((cnt_inc + LEN_WIDTH'(1)) != len_q);
              tc_d      = ((cnt_inc + LEN_WIDTH'(1)) != len_q);
            end
          end
          S_RADDR: begin
            state_d = S_RDATA;
            mode_d  = 1'b1;
            ts_d    = (len_q != LEN_WIDTH'(1));
            tc_d    = (len_q != LEN_WIDTH'(1));
          end
          S_RDATA: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (count_q == LEN_WIDTH'(i)) rdata_d[8*i +: 8] = data_rx;
            end
            count_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = S_WAIT_FREE;
            end else begin
              ts_d = ((cnt_inc + LEN_WIDTH'(1)) != len_q);
              tc_d = ((cnt_inc + LEN_WIDTH'(1)) != len_q);
            end
          end
          S_DRAIN: state_d = S_WAIT_FREE;
          default: state_d = state_q;
        endcase
      end
    end else if (tmr_q <= TMR_W'(1)) begin
      ts_d      = 1'b0;
      tc_d      = 1'b0;
      mode_d    = 1'b0;
      data_tx_d = '0;
      status_d  = ST_TIMEOUT;
      state_d   = S_RESP;
    end else begin
      tmr_d = tmr_q - TMR_W'(1);
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_status         = status_q;
  assign rsp_count          = count_q;
  assign rsp_rdata          = rdata_q;
  assign transfer_start     = ts_q;
  assign transfer_continues = tc_q;
  assign mode               = mode_q;
  assign data_tx            = data_tx_q;

endmodule

// File: tb/tb_i2c_register_master.sv
// Directed bench for i2c_register_master: the core side is driven by hand,
// expected bytes, flags and responses are hand-computed constants.
module tb_i2c_register_master;

  localparam int MAX_LEN = 4;
  localparam int LW      = 3;

  logic                 clk_in = 1'b0;
  logic                 reset;
  logic                 req_valid, req_ready, req_read;
  logic [6:0]           req_dev_addr;
  logic [7:0]           req_reg_addr;
  logic [LW-1:0]        req_len;
  logic [8*MAX_LEN-1:0] req_wdata;
  logic                 rsp_valid;
  logic [2:0]           rsp_status;
  logic [LW-1:0]        rsp_count;
  logic [8*MAX_LEN-1:0] rsp_rdata;
  logic                 transfer_start, transfer_continues, mode;
  logic [7:0]           data_tx;
  logic                 transfer_ready, transaction_complete, nack, start_err, arbitration_err;
  logic [7:0]           data_rx;

  int n_tests = 0;
  int n_fail  = 0;
  int waited;

  i2c_register_master #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(100)) dut (
    .clk_in(clk_in), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_count(rsp_count), .rsp_rdata(rsp_rdata),
    .transfer_start(transfer_start), .transfer_continues(transfer_continues),
    .mode(mode), .data_tx(data_tx),
    .transfer_ready(transfer_ready), .transaction_complete(transaction_complete),
    .nack(nack), .start_err(start_err), .arbitration_err(arbitration_err),
    .data_rx(data_rx)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic flags_chk(input string tag, input logic ts, input logic tc, input logic md);
    check({tag, ".start/cont/mode"},
          32'({transfer_start, transfer_continues, mode}), 32'({ts, tc, md}));
  endtask

  task automatic core_chk(input string tag, input logic [7:0] dtx,
                          input logic ts, input logic tc, input logic md);
    check({tag, ".data_tx"}, 32'(data_tx), 32'(dtx));
    flags_chk(tag, ts, tc, md);
  endtask

  task automatic accept(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [LW-1:0] len, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_read     = rd;
    req_dev_addr = dev;
    req_reg_addr = ra;
    req_len      = len;
    req_wdata    = wd;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("ready_low_after_accept", 32'(req_ready), 32'd0);
  endtask

  task automatic complete(input logic nk, input logic [7:0] rx);
    transaction_complete = 1'b1;
    nack                 = nk;
    data_rx              = rx;
    @(negedge clk_in);
    transaction_complete = 1'b0;
    nack                 = 1'b0;
    data_rx              = 8'h00;
  endtask

  // Frees the bus, waits for the response pulse and checks its fields.
  task automatic wait_rsp(input string tag, input logic [2:0] st, input logic [LW-1:0] cnt,
                          input logic [31:0] rd, output int lat);
    int n = 0;
    transfer_ready = 1'b1;
    while (!rsp_valid && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    lat = n;
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
    check({tag, ".status"}, 32'(rsp_status), 32'(st));
    check({tag, ".count"}, 32'(rsp_count), 32'(cnt));
    check({tag, ".rdata"}, rsp_rdata, rd);
    @(negedge clk_in);
    transfer_ready = 1'b0;
    check({tag, ".rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    check({tag, ".status_held"}, 32'(rsp_status), 32'(st));
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_dev_addr = '0; req_reg_addr = '0;
    req_len = '0; req_wdata = '0;
    transfer_ready = 1'b0; transaction_complete = 1'b0; nack = 1'b0;
    start_err = 1'b0; arbitration_err = 1'b0; data_rx = '0;
    repeat (3) @(negedge clk_in);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_fields", 32'({rsp_status, rsp_count}), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    core_chk("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk_in);

    // write dev 0x50 reg 0x10 data AB,CD
    accept(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000_CDAB);
    core_chk("wr.addr", 8'hA0, 1'b1, 1'b1, 1'b0);
    complete(1'b0, 8'h00);
    core_chk("wr.reg", 8'h10, 1'b1, 1'b1, 1'b0);
    complete(1'b0, 8'h00);
    core_chk("wr.d0", 8'hAB, 1'b1, 1'b1, 1'b0);
    complete(1'b0, 8'h00);
    core_chk("wr.d1", 8'hCD, 1'b0, 1'b0, 1'b0);
    complete(1'b0, 8'h00);
    repeat (3) @(negedge clk_in);
    check("wr.waits_for_bus", 32'(rsp_valid), 32'd0);
    wait_rsp("wr", 3'd0, 3'd2, 32'h0, waited);

    // read dev 0x50 reg 0x00, 3 bytes 11,22,33
    accept(1'b1, 7'h50, 8'h00, 3'd3, 32'h0);
    core_chk("rd.addr", 8'hA0, 1'b1, 1'b1, 1'b0);
    complete(1'b0, 8'h00);
    core_chk("rd.reg", 8'h00, 1'b1, 1'b0, 1'b0);
    complete(1'b0, 8'h00);
    core_chk("rd.raddr", 8'hA1, 1'b1, 1'b1, 1'b0);
    complete(1'b0, 8'h00);
    flags_chk("rd.b0", 1'b1, 1'b1, 1'b1);
    complete(1'b0, 8'h11);
    flags_chk("rd.b1", 1'b1, 1'b1, 1'b1);
    complete(1'b0, 8'h22);
    flags_chk("rd.b2", 1'b0, 1'b0, 1'b1);
    complete(1'b1, 8'h33);
    wait_rsp("rd", 3'd0, 3'd3, 32'h0033_2211, waited);

    // address NACK with more bytes queued -> terminator byte
    accept(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000_2211);
    complete(1'b1, 8'h00);
    core_chk("nka.term", 8'hFF, 1'b0, 1'b0, 1'b0);
    complete(1'b0, 8'h00);
    wait_rsp("nka", 3'd1, 3'd0, 32'h0, waited);

    // data NACK on the first of three bytes -> terminator byte
    accept(1'b0, 7'h21, 8'h05, 3'd3, 32'h0055_6677);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h00);
    core_chk("nkd.d0", 8'h77, 1'b1, 1'b1, 1'b0);
    complete(1'b1, 8'h00);
    core_chk("nkd.term", 8'hFF, 1'b0, 1'b0, 1'b0);
    complete(1'b0, 8'h00);
    wait_rsp("nkd", 3'd2, 3'd0, 32'h0, waited);

    // data NACK on the final byte -> no terminator, straight to bus wait
    accept(1'b0, 7'h21, 8'h06, 3'd2, 32'h0000_4433);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h00);
    core_chk("nkl.d1", 8'h44, 1'b0, 1'b0, 1'b0);
    complete(1'b1, 8'h00);
    core_chk("nkl.no_term", 8'h44, 1'b0, 1'b0, 1'b0);
    wait_rsp("nkl", 3'd2, 3'd1, 32'h0, waited);

    // arbitration lost during REG
    accept(1'b0, 7'h50, 8'h22, 3'd1, 32'h0000_0099);
    complete(1'b0, 8'h00);
    core_chk("arb.reg", 8'h22, 1'b1, 1'b1, 1'b0);
    arbitration_err = 1'b1;
    @(negedge clk_in);
    arbitration_err = 1'b0;
    flags_chk("arb.drop", 1'b0, 1'b0, 1'b0);
    wait_rsp("arb", 3'd3, 3'd0, 32'h0, waited);

    // start error wins over a same-cycle complete
    accept(1'b1, 7'h50, 8'h01, 3'd1, 32'h0);
    start_err = 1'b1;
    complete(1'b0, 8'h00);
    start_err = 1'b0;
    core_chk("serr.no_advance", 8'hA0, 1'b0, 1'b0, 1'b0);
    wait_rsp("serr", 3'd4, 3'd0, 32'h0, waited);

    // timeout: no complete at all
    accept(1'b0, 7'h3C, 8'h00, 3'd1, 32'h0000_0012);
    wait_rsp("tmo", 3'd5, 3'd0, 32'h0, waited);
    check("tmo.latency", 32'(waited), 32'd100);
    core_chk("tmo.core", 8'h00, 1'b0, 1'b0, 1'b0);

    // malformed requests
    accept(1'b1, 7'h50, 8'h00, 3'd0, 32'h0);
    check("bad0.rsp_next_cycle", 32'(rsp_valid), 32'd1);
    flags_chk("bad0.core_idle", 1'b0, 1'b0, 1'b0);
    wait_rsp("bad0", 3'd6, 3'd0, 32'h0, waited);
    flags_chk("bad0.start_never", 1'b0, 1'b0, 1'b0);
    accept(1'b0, 7'h50, 8'h00, 3'd5, 32'h0);
    check("bad5.rsp_next_cycle", 32'(rsp_valid), 32'd1);
    wait_rsp("bad5", 3'd6, 3'd0, 32'h0, waited);

    // reset in the middle of a read after one byte arrived
    accept(1'b1, 7'h50, 8'h00, 3'd2, 32'h0);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h00);
    complete(1'b0, 8'h5A);
    check("mid.partial_rdata", rsp_rdata, 32'h0000_005A);
    reset = 1'b1;
    @(negedge clk_in);
    check("mid.req_ready", 32'(req_ready), 32'd1);
    check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid.rsp_fields", 32'({rsp_status, rsp_count}), 32'd0);
    check("mid.rsp_rdata", rsp_rdata, 32'd0);
    core_chk("mid", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk_in);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
